uart_tx_cfg: RTL and testbench

//   Parametrised RS-232 UART transmitter; successor to the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_tx_cfg.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter/receiver FSM encoding and
// the frame length helper used by the configurable UART blocks.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 32'd0;
  localparam int unsigned PARITY_ODD  = 32'd1;
  localparam int unsigned PARITY_EVEN = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Serial bits in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_len(input int unsigned data_bits,
                                            input int unsigned parity,
                                            input int unsigned stop_bits);
    return 32'd1 + data_bits + ((parity != PARITY_NONE) ? 32'd1 : 32'd0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Restartable bit-period counter: bit_tick marks the last clock of each serial bit.
// Held at zero while restart is high so every frame starts on a fresh bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 32'd16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (5..9 data bits, none/odd/even parity, 1..2 stop bits)
// with a valid/ready word handshake and gap-free back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE_DIVISOR = 32'd100_000_000 / 32'd9600,
  parameter int unsigned DATA_BITS        = 32'd8,
  parameter int unsigned PARITY           = 32'd0,
  parameter int unsigned STOP_BITS        = 32'd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_bit,
  output logic                 tx_busy,
  output logic                 tx_done
);

  if ((DATA_BITS < 32'd5) || (DATA_BITS > 32'd9)) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
  end
  if ((STOP_BITS < 32'd1) || (STOP_BITS > 32'd2)) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BAUDRATE_DIVISOR < 32'd4) begin : g_bad_divisor
    $error("uart_tx_cfg: BAUDRATE_DIVISOR must be at least 4");
  end

  localparam int unsigned IDX_W = $clog2(DATA_BITS + 32'd1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 32'd1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 32'd1);
  localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    return (PARITY == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_bit_q, tx_bit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_tick;
  logic                 last_stop_s;
  logic                 accept_s;
  logic                 baud_restart_s;

  // Ready opens in the final clock of the last stop bit so a new word follows with no gap.
  assign last_stop_s    = (state_q == ST_STOP) && (idx_q == STOP_LAST) && bit_tick;
  assign tx_ready       = !rst && ((state_q == ST_IDLE) || last_stop_s);
  assign accept_s       = tx_valid && tx_ready;
  assign baud_restart_s = accept_s || (state_q == ST_IDLE);

  uart_baud_gen #(
    .DIVISOR (BAUDRATE_DIVISOR)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .restart  (baud_restart_s),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    par_d    = par_q;
    tx_bit_d = tx_bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d  = ST_START;
          shift_d  = tx_data;
          par_d    = parity_bit(tx_data);
          idx_d    = '0;
          tx_bit_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          tx_bit_d = 1'b1;
          busy_d   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d  = ST_DATA;
          idx_d    = '0;
          tx_bit_d = shift_q[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_tick && (idx_q == DATA_LAST)) begin
          state_d  = HAS_PARITY ? ST_PARITY : ST_STOP;
          idx_d    = '0;
          tx_bit_d = HAS_PARITY ? par_q : 1'b1;
        end else if (bit_tick) begin
          shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
          idx_d    = idx_q + IDX_W'(1);
          tx_bit_d = shift_q[1];
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d  = ST_STOP;
          idx_d    = '0;
          tx_bit_d = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (last_stop_s && accept_s) begin
          state_d  = ST_START;
          shift_d  = tx_data;
          par_d    = parity_bit(tx_data);
          idx_d    = '0;
          tx_bit_d = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b1;
        end else if (last_stop_s) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          tx_bit_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (bit_tick) begin
          idx_d = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        shift_d  = '0;
        idx_d    = '0;
        par_d    = 1'b0;
        tx_bit_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      par_q    <= 1'b0;
      tx_bit_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      par_q    <= par_d;
      tx_bit_q <= tx_bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_bit  = tx_bit_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench: four transmitter configurations (8N1, 8O1, 8E1, 7E2) at divisor 16,
// compared cycle by cycle against a frame model built from the serial framing rules.
module tb_uart_tx_cfg;

  localparam int DIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] valid_r = 4'b0000;
  logic [8:0] data_a [4];
  wire  [3:0] bit_v;
  wire  [3:0] ready_v;
  wire  [3:0] busy_v;
  wire  [3:0] done_v;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.BAUDRATE_DIVISOR(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_valid(valid_r[0]), .tx_data(data_a[0][7:0]),
    .tx_ready(ready_v[0]), .tx_bit(bit_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_cfg #(.BAUDRATE_DIVISOR(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_valid(valid_r[1]), .tx_data(data_a[1][7:0]),
    .tx_ready(ready_v[1]), .tx_bit(bit_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_cfg #(.BAUDRATE_DIVISOR(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_valid(valid_r[2]), .tx_data(data_a[2][7:0]),
    .tx_ready(ready_v[2]), .tx_bit(bit_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_cfg #(.BAUDRATE_DIVISOR(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst(rst), .tx_valid(valid_r[3]), .tx_data(data_a[3][6:0]),
    .tx_ready(ready_v[3]), .tx_bit(bit_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  function automatic int db_of(input int id);
    return (id == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int id);
    return (id == 3) ? 2 : id;
  endfunction
  function automatic int sb_of(input int id);
    return (id == 3) ? 2 : 1;
  endfunction
  function automatic int frame_bits(input int id);
    return 1 + db_of(id) + ((par_of(id) != 0) ? 1 : 0) + sb_of(id);
  endfunction

  // Line levels for one frame: start, data LSB first, parity making the ones count odd/even, stops.
  task automatic build_frame(input int id, input logic [8:0] word, input bit append);
    int ones;
    logic b;
    ones = 0;
    if (!append) exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_of(id); i++) begin
      exp_q.push_back(word[i]);
      if (word[i]) ones++;
    end
    if (par_of(id) == 2) begin
      b = ((ones % 2) == 1);
      exp_q.push_back(b);
    end else if (par_of(id) == 1) begin
      b = ((ones % 2) == 0);
      exp_q.push_back(b);
    end
    for (int i = 0; i < sb_of(id); i++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(input int id, input string tag, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (ready_v[id] === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s ready_timeout got 0 expected 1", tag);
    end
  endtask

  // Sends one word and checks {bit,busy,done,ready} each cycle; optionally pokes a rejected word at cycle poke_k.
  task automatic send_check(input int id, input logic [8:0] word, input int poke_k,
                            input logic [8:0] poke_word, input string tag);
    bit ok;
    int ncyc;
    logic [3:0] got, want;
    build_frame(id, word, 1'b0);
    ncyc = exp_q.size() * DIV;
    wait_ready(id, tag, ok);
    if (!ok) return;
    valid_r[id] = 1'b1;
    data_a[id]  = word;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin
        valid_r[id] = 1'b0;
        data_a[id]  = 9'($urandom_range(0, 511));
      end
      if (k == poke_k) begin
        valid_r[id] = 1'b1;
        data_a[id]  = poke_word;
      end else if (k == poke_k + 1) begin
        valid_r[id] = 1'b0;
      end
      got  = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
      want = {exp_q[k / DIV], 1'b1, 1'b0, (k == ncyc - 1)};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s k=%0d {bit,busy,done,ready} got %b expected %b", tag, k, got, want);
      end
    end
    @(negedge clk);
    got = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
    n_cmp++;
    if (got !== 4'b1011) begin
      n_bad++;
      $display("FAIL %s done_cycle {bit,busy,done,ready} got %b expected 1011", tag, got);
    end
    @(negedge clk);
    n_cmp++;
    if (done_v[id] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width got %b expected 0", tag, done_v[id]);
    end
  endtask

  task automatic check_idle(input int id, input int cycles, input string tag);
    logic [3:0] got;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      got = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++;
        $display("FAIL %s k=%0d {bit,busy,done,ready} got %b expected 1001", tag, k, got);
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      got = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
      n_cmp++;
      if (got !== 4'b1000) begin
        n_bad++;
        $display("FAIL reset id=%0d {bit,busy,done,ready} got %b expected 1000", id, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int id = 0; id < 4; id++) begin
      got = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
      n_cmp++;
      if (got !== 4'b1001) begin
        n_bad++;
        $display("FAIL reset_release id=%0d {bit,busy,done,ready} got %b expected 1001", id, got);
      end
    end
  endtask

  task automatic test_8n1();
    send_check(0, 9'h0A5, -1, 9'h000, "8n1_a5");
  endtask

  task automatic test_parity();
    send_check(1, 9'h007, -1, 9'h000, "8o1_07");
    send_check(2, 9'h007, -1, 9'h000, "8e1_07");
  endtask

  task automatic test_7e2();
    send_check(3, 9'h07F, -1, 9'h000, "7e2_7f");
  endtask

  task automatic test_back_to_back(input int id, input logic [8:0] w1, input logic [8:0] w2,
                                   input string tag);
    bit ok;
    int fc;
    logic [3:0] got, want;
    build_frame(id, w1, 1'b0);
    build_frame(id, w2, 1'b1);
    fc = frame_bits(id) * DIV;
    wait_ready(id, tag, ok);
    if (!ok) return;
    valid_r[id] = 1'b1;
    data_a[id]  = w1;
    for (int k = 0; k < 2 * fc; k++) begin
      @(negedge clk);
      if (k == 0) data_a[id] = w2;
      if (k == fc) valid_r[id] = 1'b0;
      got  = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
      want = {exp_q[k / DIV], 1'b1, (k == fc), ((k == fc - 1) || (k == 2 * fc - 1))};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s k=%0d {bit,busy,done,ready} got %b expected %b", tag, k, got, want);
      end
    end
    @(negedge clk);
    got = {bit_v[id], busy_v[id], done_v[id], ready_v[id]};
    n_cmp++;
    if (got !== 4'b1011) begin
      n_bad++;
      $display("FAIL %s final_done {bit,busy,done,ready} got %b expected 1011", tag, got);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    logic [8:0] w;
    logic [3:0] got;
    w = 9'($urandom_range(0, 255));
    build_frame(0, w, 1'b0);
    wait_ready(0, "rst_mid", ok);
    if (!ok) return;
    valid_r[0] = 1'b1;
    data_a[0]  = w;
    for (int k = 0; k < 4 * DIV + 6; k++) begin
      @(negedge clk);
      if (k == 0) valid_r[0] = 1'b0;
      n_cmp++;
      if (bit_v[0] !== exp_q[k / DIV]) begin
        n_bad++;
        $display("FAIL rst_mid_pre k=%0d tx_bit got %b expected %b", k, bit_v[0], exp_q[k / DIV]);
      end
    end
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      got = {bit_v[0], busy_v[0], done_v[0], ready_v[0]};
      n_cmp++;
      if (got !== 4'b1000) begin
        n_bad++;
        $display("FAIL rst_mid_hold c=%0d {bit,busy,done,ready} got %b expected 1000", c, got);
      end
    end
    rst = 1'b0;
    check_idle(0, 12 * DIV, "rst_mid_after");
    send_check(0, 9'h03C, -1, 9'h000, "rst_mid_3c");
  endtask

  task automatic test_ignore_busy();
    send_check(0, 9'h096, 75, 9'h033, "busy_poke");
    check_idle(0, 40, "busy_poke_idle");
    send_check(0, 9'h033, -1, 9'h000, "busy_represent");
  endtask

  task automatic test_random();
    logic [8:0] w, pw;
    int pk;
    for (int id = 0; id < 4; id++) begin
      for (int n = 0; n < 5; n++) begin
        w  = 9'($urandom_range(0, 511));
        pw = 9'($urandom_range(0, 511));
        pk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, frame_bits(id) * DIV - 2)) : -1;
        send_check(id, w, pk, pw, $sformatf("rand_id%0d_n%0d", id, n));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) data_a[i] = 9'h000;
    test_reset();
    test_8n1();
    test_parity();
    test_7e2();
    test_back_to_back(0, 9'h055, 9'h0AA, "b2b_55_aa");
    test_back_to_back(3, 9'($urandom_range(0, 127)), 9'($urandom_range(0, 127)), "b2b_7e2_rand");
    test_reset_mid_frame();
    test_ignore_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
